// File: rtl/alu_host_pkg.sv
// Shared widths, FSM state encoding and FIFO payload type for the ALU host injector.
package alu_host_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CTRL_W-1:0] ctrl;
  } host_cmd_t;

endpackage

// File: rtl/alu_host_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_host_cmd_fifo
  import alu_host_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  host_cmd_t din,
  output host_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  host_cmd_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_host_injector.sv
// Issues buffered host commands to the ALU tile one at a time and returns each
// result (or a timeout) to the host.
module alu_host_injector
  import alu_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  output logic [DATA_W-1:0] host_in_a,
  output logic [DATA_W-1:0] host_in_b,
  output logic [CTRL_W-1:0] host_in_ctrl,
  output logic              host_in_valid,
  input  logic [DATA_W-1:0] host_out_a,
  input  logic              host_out_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [7:0]        stray_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e           state;
  logic [CNT_W-1:0] to_cnt;
  host_cmd_t        cmd_in;
  host_cmd_t        head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign cmd_in    = '{a: cmd_a, b: cmd_b, ctrl: cmd_ctrl};
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;

  alu_host_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign host_in_valid = (state == ISSUE);
  assign rsp_valid     = (state == RESP);
  assign busy          = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      host_in_a    <= '0;
      host_in_b    <= '0;
      host_in_ctrl <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      stray_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            host_in_a    <= head.a;
            host_in_b    <= head.b;
            host_in_ctrl <= head.ctrl;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          to_cnt <= to_cnt + CNT_W'(1);
          // A result in the expiry cycle takes priority over the timeout.
          if (host_out_valid) begin
            rsp_data    <= host_out_a;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (host_out_valid && (state != WAIT) && (stray_count != '1))
        stray_count <= stray_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_host_injector.sv
// Directed scoreboard bench for alu_host_injector with a latency-programmable tile model.
module tb_alu_host_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_a, cmd_b;
  logic [15:0] cmd_ctrl;
  logic [63:0] host_in_a, host_in_b;
  logic [15:0] host_in_ctrl;
  logic        host_in_valid;
  logic [63:0] host_out_a;
  logic        host_out_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;
  logic [7:0]  stray_count;

  alu_host_injector #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_ctrl       (cmd_ctrl),
    .host_in_a      (host_in_a),
    .host_in_b      (host_in_b),
    .host_in_ctrl   (host_in_ctrl),
    .host_in_valid  (host_in_valid),
    .host_out_a     (host_out_a),
    .host_out_valid (host_out_valid),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy),
    .stray_count    (stray_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned n_pulse = 0;
  int unsigned pulse_cyc = 0;
  int unsigned n_rise = 0;
  int unsigned rise_cyc = 0;
  int unsigned hs_cyc = 0;
  logic        rsp_prev = 1'b0;

  // Tile model: answers a+b tile_lat cycles after each pulse; tile_lat = 0 never answers.
  int unsigned tile_lat = 0;
  int unsigned pend = 0;
  logic [63:0] pend_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    host_out_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        host_out_valid = 1'b1;
        host_out_a     = pend_data;
      end
    end
    if (host_in_valid && tile_lat > 0) begin
      pend      = tile_lat;
      pend_data = host_in_a + host_in_b;
    end
  end

  always @(negedge clk) begin
    if (host_in_valid) begin
      n_pulse++;
      pulse_cyc = cyc;
    end
    if (rsp_valid && !rsp_prev) begin
      n_rise++;
      rise_cyc = cyc;
    end
    rsp_prev = rsp_valid;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [63:0] a, input logic [63:0] b, input logic [15:0] c,
                          input logic [63:0] ed, input logic et, input bit track);
    int unsigned w = 0;
    exp_t e;
    cmd_a = a; cmd_b = b; cmd_ctrl = c; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("push_wait_expired", 64'(cmd_ready), 64'd1);
    hs_cyc = cyc;
    e.d = ed;
    e.to = et;
    if (track) exp_q.push_back(e);
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned p0, r0, t0, w;
    logic [63:0] d0;
    logic        stable;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_ctrl = '0;
    rsp_ready = 1'b1; host_out_valid = 1'b0; host_out_a = '0;
    repeat (3) sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_host_in_valid", 64'(host_in_valid), 64'd0);
    chk("rst_stray", 64'(stray_count), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_host_in_a", host_in_a, 64'd0);
    sync();

    // Single op: tile answers 3 cycles after the pulse.
    tile_lat = 3;
    p0 = n_pulse;
    push_cmd(64'd5, 64'd7, 16'h0001, 64'hC, 1'b0, 1'b1);
    t0 = hs_cyc;
    wait_drain();
    chk("single_pulses", 64'(n_pulse - p0), 64'd1);
    chk("single_pulse_cyc", 64'(pulse_cyc), 64'(t0 + 2));
    chk("single_rsp_cyc", 64'(rise_cyc), 64'(t0 + 6));
    chk("single_ctrl_hold", 64'(host_in_ctrl), 64'h0001);
    chk("single_a_hold", host_in_a, 64'd5);

    // FIFO full: first op issued while tile is stalled (times out), four fill the FIFO.
    tile_lat = 0;
    push_cmd(64'd10, 64'd1, 16'h0010, 64'd0, 1'b1, 1'b1);
    push_cmd(64'd20, 64'd2, 16'h0011, 64'd22, 1'b0, 1'b1);
    push_cmd(64'd30, 64'd3, 16'h0012, 64'd33, 1'b0, 1'b1);
    push_cmd(64'd40, 64'd4, 16'h0013, 64'd44, 1'b0, 1'b1);
    push_cmd(64'd50, 64'd5, 16'h0014, 64'd55, 1'b0, 1'b1);
    tile_lat = 3;
    @(negedge clk);
    chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    wait_drain();
    chk("full_cmd_ready_after", 64'(cmd_ready), 64'd1);

    // Timeout: tile answers only at i+12, after expiry, which counts as stray.
    tile_lat = 12;
    push_cmd(64'd1, 64'd2, 16'h0020, 64'd0, 1'b1, 1'b1);
    wait_drain();
    chk("to_rsp_cyc", 64'(rise_cyc), 64'(pulse_cyc + 9));
    w = 0;
    while (cyc < pulse_cyc + 14 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("to_stray", 64'(stray_count), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    sync();

    // Collision: result lands in the expiry cycle and wins.
    tile_lat = 8;
    push_cmd(64'd3, 64'd4, 16'h0030, 64'd7, 1'b0, 1'b1);
    wait_drain();
    chk("coll_rsp_cyc", 64'(rise_cyc), 64'(pulse_cyc + 9));
    repeat (3) @(negedge clk);
    chk("coll_stray", 64'(stray_count), 64'd1);
    sync();

    // Backpressure: response held while the FIFO fills behind it.
    rsp_ready = 1'b0;
    tile_lat = 2;
    push_cmd(64'd100, 64'd23, 16'h0040, 64'd123, 1'b0, 1'b1);
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_rsp_data", rsp_data, 64'd123);
    d0 = rsp_data;
    p0 = n_pulse;
    sync();
    push_cmd(64'd1, 64'd1, 16'h0041, 64'd2, 1'b0, 1'b1);
    push_cmd(64'd2, 64'd2, 16'h0042, 64'd4, 1'b0, 1'b1);
    push_cmd(64'd3, 64'd3, 16'h0043, 64'd6, 1'b0, 1'b1);
    push_cmd(64'd4, 64'd4, 16'h0044, 64'd8, 1'b0, 1'b1);
    stable = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_no_pulse", 64'(n_pulse), 64'(p0));
    chk("bp_full", 64'(cmd_ready), 64'd0);
    sync();
    rsp_ready = 1'b1;
    wait_drain();

    // Reset mid-WAIT with two commands queued behind the in-flight op.
    tile_lat = 6;
    p0 = n_pulse;
    push_cmd(64'd7, 64'd7, 16'h0050, 64'd0, 1'b0, 1'b0);
    push_cmd(64'd8, 64'd8, 16'h0051, 64'd0, 1'b0, 1'b0);
    push_cmd(64'd9, 64'd9, 16'h0052, 64'd0, 1'b0, 1'b0);
    w = 0;
    while (n_pulse == p0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_issued", 64'(n_pulse - p0), 64'd1);
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    p0 = n_pulse;
    r0 = n_rise;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_mid_stray", 64'(stray_count), 64'd0);
    repeat (10) @(negedge clk);
    chk("rst_mid_no_rsp", 64'(n_rise), 64'(r0));
    chk("rst_mid_no_pulse", 64'(n_pulse), 64'(p0));
    chk("rst_mid_late_stray", 64'(stray_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
